// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the 4-way round-robin arbiter:
//     - state_t          : arbiter FSM states (IDLE = no owner, GRANT = owner)
//     - NUM_REQ          : number of requesters
//     - DEFAULT_MAX_HOLD : default grant-hold limit used by the timeout option
//     - gnt_decode()     : owner index + busy flag -> active-low one-hot grant
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ          = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

  // All lines stay high unless a grant is active; then only the owner's
  // line goes low.
  function automatic logic [NUM_REQ-1:0] gnt_decode(input logic       busy,
                                                    input logic [1:0] id);
    logic [NUM_REQ-1:0] lines;
    lines = '1;
    if (busy) begin
      lines[id] = 1'b0;
    end
    return lines;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
//   Combinational round-robin search over four request lines. Looks at
//   start, start+1, start+2, start+3 (mod 4) and reports the first set line.
//
//   Ports
//     req   [3:0] in   candidate request lines (already masked by caller)
//     start [1:0] in   index checked first
//     found       out  high when any req bit is set
//     index [1:0] out  chosen requester (equals start when found=0)
// ---------------------------------------------------------------------------
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] index
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set line,
  // written last, wins.
  always_comb begin
    found = 1'b0;
    index = start;
    cand  = start;
    for (int i = 3; i >= 0; i--) begin
      cand = start + 2'(i);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
//   Four-requester round-robin arbiter with registered, active-low one-hot
//   grants. An owner keeps the grant while its request stays high. On
//   release the grant passes directly to the next requester in round-robin
//   order, or the arbiter goes idle.
//
//   Optional feature (macro ARB_TIMEOUT_EN):
//     An owner that has held the grant for MAX_HOLD cycles while someone
//     else is waiting is forcibly rotated, and timeout pulses for one cycle.
//     Without the macro there is no hold counter and timeout is tied low.
//
//   Parameters
//     MAX_HOLD  grant-hold limit for the timeout option (2..15)
//     CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
//   Ports
//     clk          in   clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     req    [3:0] in   request lines, active high
//     gnt_n  [3:0] out  grant lines, active-low one-hot
//     gnt_id [1:0] out  current owner index (valid while busy)
//     busy         out  a grant is active
//     timeout      out  one-cycle pulse when a grant is forcibly rotated
// ---------------------------------------------------------------------------
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt_n,
  output logic [1:0]         gnt_id,
  output logic               busy,
  output logic               timeout
);

  // Reject illegal configurations at elaboration time.
  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be in 2..15");
  end
  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("rr_arbiter4: CNT_W too narrow for MAX_HOLD");
  end

  state_t     state;
  state_t     state_nxt;
  logic [1:0] last;
  logic [1:0] last_nxt;
  logic [1:0] id_nxt;
  logic       busy_nxt;
  logic       timeout_nxt;

  logic [3:0] pick_req;
  logic [1:0] pick_start;
  logic       pick_found;
  logic [1:0] pick_index;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_cnt;
  logic             new_grant;
`endif

  // One search serves both the idle grant and the handover/rotation. While
  // an owner exists, last equals the owner, so starting at last+1 and
  // masking the owner out gives the owner-excluded search.
  always_comb begin
    pick_start = last + 2'd1;
    pick_req   = req;
    if (state == GRANT) begin
      pick_req[gnt_id] = 1'b0;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .index (pick_index)
  );

  // Next-state and next-output logic. A granted owner is only replaced on
  // release or, with the timeout option, at the hold limit.
  always_comb begin
    state_nxt   = state;
    busy_nxt    = busy;
    id_nxt      = gnt_id;
    last_nxt    = last;
    timeout_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          busy_nxt  = 1'b1;
          id_nxt    = pick_index;
          last_nxt  = pick_index;
        end
      end

      GRANT: begin
        if (!req[gnt_id]) begin
          if (pick_found) begin
            id_nxt   = pick_index;
            last_nxt = pick_index;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST && pick_found) begin
          id_nxt      = pick_index;
          last_nxt    = pick_index;
          timeout_nxt = 1'b1;
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Main state and output registers. gnt_n is decoded from the next owner
  // so it changes on the same edge as gnt_id and busy, and is cleared by
  // the asynchronous reset together with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      gnt_id <= 2'b00;
      gnt_n  <= '1;
      last   <= 2'b11;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      gnt_id <= id_nxt;
      gnt_n  <= gnt_decode(busy_nxt, id_nxt);
      last   <= last_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // A handover never returns to the released owner, so a change of index
  // or leaving idle identifies every fresh grant, including rotations.
  assign new_grant = busy_nxt && (!busy || (id_nxt != gnt_id));

  // Hold counter: cleared on each fresh grant, then counts owned cycles
  // and parks at the limit so an unopposed owner keeps the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_nxt;
      if (new_grant) begin
        hold_cnt <= '0;
      end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4
//   Directed self-checking bench for rr_arbiter4 (default MAX_HOLD = 8).
//   Expected values are hand-computed; the long-hold section picks its
//   expectation according to ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt_n;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int vec_count;
  int err_count;

  rr_arbiter4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt_n   (gnt_n),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request pattern, let one rising edge take it, then settle.
  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Check that a grant to id is visible on all outputs.
  task automatic checkGrant(input string tag, input logic [1:0] id);
    logic [3:0] exp_n;
    exp_n     = 4'hF;
    exp_n[id] = 1'b0;
    checkOutput({tag, ".id"},   8'(gnt_id), 8'(id));
    checkOutput({tag, ".gnt"},  8'(gnt_n),  8'(exp_n));
    checkOutput({tag, ".busy"}, 8'(busy),   8'd1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".gnt"},  8'(gnt_n), 8'hF);
    checkOutput({tag, ".busy"}, 8'(busy),  8'd0);
  endtask

  initial begin
    logic [1:0] exp_id;
    logic       exp_to;
    vec_count = 0;
    err_count = 0;
    rst_n     = 1'b0;
    req       = 4'b1111;

    // Reset held with all requests present.
    applyStimulus(4'b1111);
    applyStimulus(4'b1111);
    checkIdle("rst");
    checkOutput("rst.id", 8'(gnt_id), 8'd0);
    checkOutput("rst.to", 8'(timeout), 8'd0);

    // Release between edges; first edge grants requester 0.
    rst_n = 1'b1;
    applyStimulus(4'b1111);
    checkGrant("rel", 2'd0);

    // Rotation: each owner drops for one cycle; no idle in between.
    applyStimulus(4'b1110);
    checkGrant("rot1", 2'd1);
    applyStimulus(4'b1101);
    checkGrant("rot2", 2'd2);
    applyStimulus(4'b1011);
    checkGrant("rot3", 2'd3);
    applyStimulus(4'b0111);
    checkGrant("rot0", 2'd0);

    applyStimulus(4'b0000);
    checkIdle("idle1");

    // Single requester 2 for five cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100);
      checkGrant("single", 2'd2);
    end
    applyStimulus(4'b0000);
    checkIdle("single.rel");
    // last = 2, so all-request search starts at 3.
    applyStimulus(4'b1111);
    checkGrant("last2", 2'd3);

    // Handover exclusion: owner 1 drops while 3 and 2 request.
    applyStimulus(4'b0000);
    checkIdle("idle2");
    applyStimulus(4'b0010);
    checkGrant("own1", 2'd1);
    applyStimulus(4'b1100);
    checkGrant("excl", 2'd2);
    // Lower requester raising does not pre-empt owner 2.
    applyStimulus(4'b0110);
    checkGrant("nopre", 2'd2);
    // Owner 2 drops; search wraps 3 -> 0 -> 1.
    applyStimulus(4'b0010);
    checkGrant("wrap", 2'd1);
    applyStimulus(4'b0000);
    checkIdle("idle3");

    // Long hold with a competitor: last = 1, search from 2 picks 0.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(4'b0011);
`ifdef ARB_TIMEOUT_EN
      exp_id = (k <= 8) ? 2'd0 : 2'd1;
      exp_to = (k == 9);
`else
      exp_id = 2'd0;
      exp_to = 1'b0;
`endif
      checkGrant($sformatf("hold%0d", k), exp_id);
      checkOutput($sformatf("hold%0d.to", k), 8'(timeout), 8'(exp_to));
    end
    applyStimulus(4'b0000);
    checkIdle("idle4");

    // Unopposed owner is never timed out.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(4'b0001);
      checkGrant($sformatf("solo%0d", k), 2'd0);
      checkOutput($sformatf("solo%0d.to", k), 8'(timeout), 8'd0);
    end

    // Asynchronous reset in mid-grant takes effect before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("arst");
    checkOutput("arst.id", 8'(gnt_id), 8'd0);
    applyStimulus(4'b1111);
    checkIdle("arst.hold");
    rst_n = 1'b1;
    applyStimulus(4'b1111);
    checkGrant("arst.rel", 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive granted cycles per owner when ARB_TIMEOUT_EN is defined; legal range 2..15.
REQ-002 Parameter: CNT_W, default 4, width of hold counter; SHALL satisfy 2**CNT_W > MAX_HOLD.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  4  request lines, active-high; bit i = requester i.
REQ-006 Port: gnt_n  output  4  grant lines, active-low one-hot; at most one bit low.
REQ-007 Port: gnt_id  output  2  encoded index of current owner; meaningful only when busy=1.
REQ-008 Port: busy  output  1  high while any grant is active.
REQ-009 Port: timeout  output  1  one-cycle pulse on the cycle a grant is forcibly rotated.

Function
REQ-010 FSM states SHALL be IDLE (no owner) and GRANT (one owner); all outputs SHALL be registered.
REQ-011 In IDLE: if req!=0 at a rising edge, SHALL enter GRANT with the winner chosen by round-robin search starting at index (last+1) mod 4; busy, gnt_n, and gnt_id SHALL be updated at that same edge (1-cycle latency from req).
REQ-012 "last" pointer SHALL hold the most recent owner; reset value 3, so the first search starts at requester 0.
REQ-013 gnt_n SHALL equal the 2-to-4 active-low decode of gnt_id while busy=1, and 4'b1111 otherwise.
REQ-014 In GRANT: while req[owner]=1, the grant SHALL be held (subject to REQ-017).
REQ-015 In GRANT, at the edge where req[owner]=0: if any other req bit is set, SHALL hand over directly to the next round-robin winner, searching from owner+1, with no idle bubble; else SHALL return to IDLE with gnt_n=4'b1111 and busy=0.
REQ-016 A requester that drops and re-raises req SHALL NOT pre-empt a current owner; requests are never queued beyond the live req level.
REQ-017 Simultaneous release by the owner and new requests SHALL follow REQ-015; the released owner SHALL be excluded from that search.
REQ-018 Hold counter SHALL clear on every new grant and increment each cycle in GRANT, saturating at MAX_HOLD-1.
REQ-019 Reset asserted mid-grant SHALL immediately force IDLE outputs regardless of clk.

Reset
REQ-020 While rst_n=0: state=IDLE, gnt_n=4'b1111, gnt_id=2'b00, busy=0, timeout=0, last=2'b11, hold counter=0.
REQ-021 Reset assertion SHALL be asynchronous; deassertion is taken synchronously by the first rising clk edge after rst_n=1.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: when the hold counter equals MAX_HOLD-1, req[owner]=1, and another req bit is set, the next edge SHALL rotate the grant to the next round-robin winner and pulse timeout high for that one cycle; with no other requester, the owner SHALL keep the grant and the counter SHALL stay saturated.
REQ-023 ARB_TIMEOUT_EN undefined: no hold counter logic; grant held until release; timeout SHALL be tied to 0.

Structure
REQ-024 Shared package arb_pkg SHALL hold the FSM state enum (IDLE, GRANT), the requester count constant (4), and the default MAX_HOLD.
REQ-025 The round-robin next-winner search SHALL be a sub-module rr_pick4 (inputs req, start index; outputs found, index), reused for both IDLE grant and handover.
REQ-026 The active-low output decode SHALL be a combinational decode of registered gnt_id/busy into a registered gnt_n.

Verification
REQ-027 Reset: hold rst_n=0 with req=4'b1111 -> gnt_n=4'b1111, busy=0; release -> gnt_id=0, gnt_n=4'b1110 one edge later.
REQ-028 Rotation: req=4'b1111 constant, each owner drops req for 1 cycle after its grant -> grant order 0,1,2,3,0 with no idle cycles.
REQ-029 Single requester: req=4'b0100 for 5 cycles then 0 -> gnt_n=4'b1011 for 5 cycles, then 4'b1111, busy=0, last=2.
REQ-030 Handover exclusion: owner 1 drops req while req[3:2]=2'b11 in the same cycle -> next grant goes to 2, not 1.
REQ-031 Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=4'b0011 held -> owner 0 for 8 cycles, timeout pulses once, owner 1 next; with req=4'b0001 only -> no timeout, grant held.
REQ-032 Async reset mid-grant: rst_n pulled low between clk edges during GRANT -> gnt_n=4'b1111 immediately, before the next edge.
